branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
Parametrised successor to the combinational branch selector. Resolves all six RV64I conditional branches against a registered, handshaked result stage. Owns a 2-bit saturating branch history table (BHT) that serves fetch-stage predictions. Sits between execute and the PC mux, where it raises a redirect on misprediction and maintains performance counters.

Parameters:
XLEN, 64, operand/PC width
BHT_ENTRIES, 16, number of BHT counters; power of two, >= 2
CNT_W, 32, width of each performance counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
fetch_pc  input  XLEN  PC being fetched; indexes the BHT for prediction
fetch_pred_taken  output  1  BHT prediction for fetch_pc; combinational read
in_valid  input  1  resolve request valid
in_ready  output  1  stage can accept a request
is_branch  input  1  request is a conditional branch; 0 = pass-through
funct3  input  3  branch condition
pc  input  XLEN  branch PC
rs1  input  XLEN  first operand
rs2  input  XLEN  second operand
imm  input  XLEN  sign-extended branch offset
pred_taken  input  1  prediction fetch used for this instruction
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
taken  output  1  resolved direction
target  output  XLEN  pc + imm
redirect  output  1  misprediction; flush younger instructions
redirect_pc  output  XLEN  correct next PC
illegal  output  1  funct3 is 010 or 011 with is_branch=1
branch_count  output  CNT_W  accepted legal branches
mispredict_count  output  CNT_W  accepted legal mispredicted branches

Behaviour:
- Reset: out_valid=0, taken=0, redirect=0, illegal=0, target=0, redirect_pc=0, both counters=0, every BHT entry=2'b01 (weakly not-taken). Reset takes effect immediately, drops any held result, and restores the BHT to this state.
- Handshake: accept occurs when in_valid && in_ready. in_ready = !out_valid || out_ready. Output is held stable while out_valid && !out_ready.
- Latency: one cycle. Output registers load on the accept edge. out_valid clears on an edge with out_ready and no new accept.
- Conditions: 000 beq (eq); 001 bne (!eq); 100 blt (signed <); 101 bge (signed >=); 110 bltu (unsigned <); 111 bgeu (unsigned >=).
- Arithmetic: target = pc + imm, truncated to XLEN bits (wraps modulo 2^XLEN). Fall-through PC = pc + 4, also wrapping.
- redirect = is_branch && !illegal && (taken != pred_taken). redirect_pc = taken ? target : pc + 4.
- Illegal funct3: taken=0, redirect=0, illegal=1. No BHT update and no counter change.
- is_branch=0: taken=0, redirect=0, illegal=0, target still computed. No BHT update and no counter change.
- BHT index = pc[$clog2(BHT_ENTRIES)+1:2], for both fetch_pc and pc. fetch_pred_taken = counter[1].
- BHT update on accept of a legal branch: taken increments the counter, saturating at 11; not-taken decrements it, saturating at 00.
- Same-cycle fetch read and update of the same entry: the read returns the pre-update value.
- Counters: branch_count increments on each accepted legal branch. mispredict_count increments when that branch also sets redirect. Both wrap to 0 after 2^CNT_W-1.

Decomposition:
- Package branch_pkg: funct3 localparams (F3_BEQ..F3_BGEU), BHT counter encodings (SNT=00, WNT=01, WT=10, ST=11), reset value WNT.
- Sub-module bht_2bit, parametrised by BHT_ENTRIES and XLEN: one asynchronous read port, one synchronous update port, asynchronous reset. The top level holds the compare logic, output stage, and counters.

Test Plan:
- beq with rs1=rs2=5, pc=0x100, imm=0x20, pred_taken=0 -> one cycle later out_valid=1, taken=1, target=0x120, redirect=1, redirect_pc=0x120, mispredict_count=1.
- blt vs bltu with rs1=all-ones, rs2=1 -> blt taken=1, bltu taken=0. bge rs1=rs2 -> taken=1.
- Backpressure: out_ready=0 with a result held -> in_ready=0, outputs stable for 3 cycles, second request accepted only after out_ready=1.
- BHT training: four taken branches at pc=0x40 -> fetch_pc=0x40 counter goes 01→10→11→11, fetch_pred_taken=1 after the first update. Four not-taken branches at the same pc -> counter saturates at 00.
- funct3=010, and separately is_branch=0 -> illegal=1 / illegal=0 respectively, with no BHT or counter change. pc=all-ones-minus-3 with imm=8 -> target wraps to 4.
- Assert reset while out_valid=1 -> out_valid=0 immediately, counters=0, all BHT entries read back 01.

Source files
------------

// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_pkg
// Description : Shared encodings for the branch resolve unit: RV64I branch
//               funct3 codes, 2-bit BHT counter states and small helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_pkg;

  // Conditional branch funct3 encodings (010 and 011 are reserved)
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // 2-bit saturating counter states; bit 1 is the predicted direction
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam logic [1:0] BHT_RESET = WNT;

  // The two reserved codes are exactly those with bit 2 clear and bit 1 set
  function automatic logic f3_is_legal(input logic [2:0] f3);
    return f3[2] || !f3[1];
  endfunction

  // Saturating step of a 2-bit counter towards the resolved direction
  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != ST) nxt = ctr + 2'b01;
    end else begin
      if (ctr != SNT) nxt = ctr - 2'b01;
    end
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bht_2bit.sv
`default_nettype none
// ============================================================================
// Module      : bht_2bit
// Description : Table of 2-bit saturating branch counters indexed by
//               pc[log2(BHT_ENTRIES)+1:2]. One asynchronous read port for
//               fetch, one synchronous update port for resolved branches.
// Revision    : 1.0 - initial release
// ============================================================================
module bht_2bit
  import branch_pkg::*;
#(
  parameter int BHT_ENTRIES = 16,
  parameter int XLEN        = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] i_rd_pc,
  output logic            o_rd_taken,
  input  logic            i_upd_en,
  input  logic [XLEN-1:0] i_upd_pc,
  input  logic            i_upd_taken
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]       r_ctr [BHT_ENTRIES];
  logic [IDX_W-1:0] w_rd_idx;
  logic [IDX_W-1:0] w_upd_idx;
  logic             w_unused_pc_bits;

  assign w_rd_idx  = i_rd_pc[IDX_W+1:2];
  assign w_upd_idx = i_upd_pc[IDX_W+1:2];

  // Bits outside the index field never affect the table
  assign w_unused_pc_bits = ^{i_rd_pc[XLEN-1:IDX_W+2], i_rd_pc[1:0],
                              i_upd_pc[XLEN-1:IDX_W+2], i_upd_pc[1:0]};

  // Reads see the registered value, so a same-cycle update is not visible yet
  assign o_rd_taken = r_ctr[w_rd_idx][1];

  // Counter storage: reset to weakly not-taken, step on each legal resolution
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        r_ctr[i] <= BHT_RESET;
      end
    end else if (i_upd_en) begin
      r_ctr[w_upd_idx] <= ctr_step(r_ctr[w_upd_idx], i_upd_taken);
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit
// Description : Resolves RV64I conditional branches into a registered,
//               valid/ready result stage, raises redirects on misprediction,
//               trains a 2-bit BHT and keeps branch/mispredict counters.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int BHT_ENTRIES = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  fetch_pc,
  output logic             fetch_pred_taken,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_branch,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [XLEN-1:0]  imm,
  input  logic             pred_taken,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic [XLEN-1:0]  target,
  output logic             redirect,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             illegal,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam logic [XLEN-1:0] c_insn_bytes = XLEN'(4);

  // Request-side combinational results
  logic            w_accept;
  logic            w_legal;
  logic            w_eq;
  logic            w_lt;
  logic            w_ltu;
  logic            w_cond;
  logic            w_taken;
  logic            w_illegal;
  logic            w_redirect;
  logic            w_upd;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_fall_pc;
  logic [XLEN-1:0] w_redirect_pc;

  // Result stage and counters
  logic             r_out_valid;
  logic             r_taken;
  logic [XLEN-1:0]  r_target;
  logic             r_redirect;
  logic [XLEN-1:0]  r_redirect_pc;
  logic             r_illegal;
  logic [CNT_W-1:0] r_branch_count;
  logic [CNT_W-1:0] r_mispredict_count;

  // A held result blocks new work until the consumer takes it
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  assign w_eq  = (rs1 == rs2);
  assign w_lt  = ($signed(rs1) < $signed(rs2));
  assign w_ltu = (rs1 < rs2);

  // Select the comparison named by funct3; reserved codes never take
  always_comb begin
    w_cond = 1'b0;
    case (funct3)
      F3_BEQ:  w_cond = w_eq;
      F3_BNE:  w_cond = !w_eq;
      F3_BLT:  w_cond = w_lt;
      F3_BGE:  w_cond = !w_lt;
      F3_BLTU: w_cond = w_ltu;
      F3_BGEU: w_cond = !w_ltu;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_legal       = f3_is_legal(funct3);
  assign w_taken       = is_branch && w_legal && w_cond;
  assign w_illegal     = is_branch && !w_legal;
  assign w_redirect    = is_branch && w_legal && (w_taken != pred_taken);
  assign w_target      = pc + imm;
  assign w_fall_pc     = pc + c_insn_bytes;
  assign w_redirect_pc = w_taken ? w_target : w_fall_pc;

  // Only accepted legal branches train the predictor and count
  assign w_upd = w_accept && is_branch && w_legal;

  // Result stage: load on accept, drop valid once consumed with nothing new
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid   <= 1'b0;
      r_taken       <= 1'b0;
      r_target      <= '0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
      r_illegal     <= 1'b0;
    end else if (w_accept) begin
      r_out_valid   <= 1'b1;
      r_taken       <= w_taken;
      r_target      <= w_target;
      r_redirect    <= w_redirect;
      r_redirect_pc <= w_redirect_pc;
      r_illegal     <= w_illegal;
    end else if (out_ready) begin
      r_out_valid   <= 1'b0;
    end
  end

  // Performance counters, free-running with natural wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else if (w_upd) begin
      r_branch_count <= r_branch_count + CNT_W'(1);
      if (w_redirect) begin
        r_mispredict_count <= r_mispredict_count + CNT_W'(1);
      end
    end
  end

  assign out_valid        = r_out_valid;
  assign taken            = r_taken;
  assign target           = r_target;
  assign redirect         = r_redirect;
  assign redirect_pc      = r_redirect_pc;
  assign illegal          = r_illegal;
  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;

  bht_2bit #(
    .BHT_ENTRIES (BHT_ENTRIES),
    .XLEN        (XLEN)
  ) u_bht (
    .clk         (clk),
    .reset       (reset),
    .i_rd_pc     (fetch_pc),
    .o_rd_taken  (fetch_pred_taken),
    .i_upd_en    (w_upd),
    .i_upd_pc    (pc),
    .i_upd_taken (w_taken)
  );

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve_unit
// Description : Self-checking bench: directed vector table, hand-written
//               handshake/BHT/reset sequences and a randomized run against a
//               behavioural model of the branch resolve unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

  localparam int XLEN        = 64;
  localparam int BHT_ENTRIES = 16;
  localparam int CNT_W       = 32;
  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic             clk = 1'b0;
  logic             reset;
  logic [XLEN-1:0]  fetch_pc;
  logic             fetch_pred_taken;
  logic             in_valid;
  logic             in_ready;
  logic             is_branch;
  logic [2:0]       funct3;
  logic [XLEN-1:0]  pc, rs1, rs2, imm;
  logic             pred_taken;
  logic             out_valid;
  logic             out_ready;
  logic             taken;
  logic [XLEN-1:0]  target;
  logic             redirect;
  logic [XLEN-1:0]  redirect_pc;
  logic             illegal;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  int checks   = 0;
  int failures = 0;

  branch_resolve_unit #(
    .XLEN(XLEN), .BHT_ENTRIES(BHT_ENTRIES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .fetch_pc(fetch_pc), .fetch_pred_taken(fetch_pred_taken),
    .in_valid(in_valid), .in_ready(in_ready), .is_branch(is_branch), .funct3(funct3),
    .pc(pc), .rs1(rs1), .rs2(rs2), .imm(imm), .pred_taken(pred_taken),
    .out_valid(out_valid), .out_ready(out_ready), .taken(taken), .target(target),
    .redirect(redirect), .redirect_pc(redirect_pc), .illegal(illegal),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic isb, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] p, input logic [63:0] i,
                       input logic pt);
    in_valid = 1'b1; is_branch = isb; funct3 = f3;
    rs1 = a; rs2 = b; pc = p; imm = i; pred_taken = pt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural meaning of one request, straight from the branch rules
  function automatic void ref_resolve(input logic isb, input logic [2:0] f3,
                                      input logic [63:0] a, input logic [63:0] b,
                                      input logic [63:0] p, input logic [63:0] i,
                                      input logic pt, output logic tk, output logic il,
                                      output logic rd, output logic [63:0] tg,
                                      output logic [63:0] rp);
    logic legal;
    legal = !(f3 == 3'b010 || f3 == 3'b011);
    tk = 1'b0;
    if (isb && legal) begin
      case (f3)
        3'b000:  tk = (a == b);
        3'b001:  tk = (a != b);
        3'b100:  tk = ($signed(a) <  $signed(b));
        3'b101:  tk = ($signed(a) >= $signed(b));
        3'b110:  tk = (a <  b);
        3'b111:  tk = (a >= b);
        default: tk = 1'b0;
      endcase
    end
    il = isb && !legal;
    tg = p + i;
    rd = isb && legal && (tk != pt);
    rp = tk ? tg : p + 64'd4;
  endfunction

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(3))
      0:       return 64'd0;
      1:       return ALL1;
      2:       return {$urandom, $urandom};
      default: return 64'($urandom_range(7));
    endcase
  endfunction

  typedef struct {
    logic        isb;
    logic [2:0]  f3;
    logic [63:0] a, b, p, i;
    logic        pt;
    logic        e_tk, e_il, e_rd;
    logic [63:0] e_tg, e_rp;
  } vec_t;

  vec_t vecs [10];

  // Model state for the randomized run
  logic [1:0]  m_bht [BHT_ENTRIES];
  logic        m_valid, m_tk, m_il, m_rd;
  logic [63:0] m_tg, m_rp;
  logic [31:0] m_br, m_mp;

  // BHT training expectations at pc 0x40
  logic        train_dir [10];
  int          train_ctr [10];
  int          pre_ctr;

  logic        r_tk, r_il, r_rd;
  logic [63:0] r_tg, r_rp;
  logic        exp_ready;

  initial begin
    vecs[0] = '{1, 3'b100, ALL1, 64'd1, 64'h200, 64'h10, 0, 1, 0, 1, 64'h210, 64'h210};
    vecs[1] = '{1, 3'b110, ALL1, 64'd1, 64'h200, 64'h10, 0, 0, 0, 0, 64'h210, 64'h204};
    vecs[2] = '{1, 3'b101, 64'd7, 64'd7, 64'h300, 64'hFFFF_FFFF_FFFF_FFF8, 1, 1, 0, 0, 64'h2F8, 64'h2F8};
    vecs[3] = '{1, 3'b001, 64'd3, 64'd3, 64'h400, 64'h40, 1, 0, 0, 1, 64'h440, 64'h404};
    vecs[4] = '{1, 3'b111, 64'd1, ALL1, 64'h500, 64'h8, 0, 0, 0, 0, 64'h508, 64'h504};
    vecs[5] = '{1, 3'b010, 64'd0, 64'd0, 64'h600, 64'h10, 1, 0, 1, 0, 64'h610, 64'h604};
    vecs[6] = '{0, 3'b000, 64'd9, 64'd9, 64'h700, 64'h20, 1, 0, 0, 0, 64'h720, 64'h704};
    vecs[7] = '{1, 3'b000, 64'd0, 64'd0, ALL1 - 64'd3, 64'd8, 1, 1, 0, 0, 64'd4, 64'd4};
    vecs[8] = '{1, 3'b001, 64'd0, 64'd0, ALL1 - 64'd3, 64'd8, 0, 0, 0, 0, 64'd4, 64'd0};
    vecs[9] = '{1, 3'b101, ALL1, 64'd0, 64'h800, 64'h100, 1, 0, 0, 1, 64'h900, 64'h804};

    train_dir = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
    train_ctr = '{2, 3, 3, 3, 2, 1, 0, 0, 1, 2};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; fetch_pc = '0;
    drive(0, 3'b000, 0, 0, 0, 0, 0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;

    // Reset state
    chk("reset.out_valid", out_valid, 0);
    chk("reset.taken", taken, 0);
    chk("reset.redirect", redirect, 0);
    chk("reset.illegal", illegal, 0);
    chk("reset.target", target, 0);
    chk("reset.redirect_pc", redirect_pc, 0);
    chk("reset.branch_count", branch_count, 0);
    chk("reset.mispredict_count", mispredict_count, 0);
    chk("reset.in_ready", in_ready, 1);
    chk("reset.fetch_pred", fetch_pred_taken, 0);

    // First branch: beq taken but predicted not-taken
    drive(1, 3'b000, 64'd5, 64'd5, 64'h100, 64'h20, 0);
    tick();
    in_valid = 1'b0;
    chk("beq.out_valid", out_valid, 1);
    chk("beq.taken", taken, 1);
    chk("beq.target", target, 64'h120);
    chk("beq.redirect", redirect, 1);
    chk("beq.redirect_pc", redirect_pc, 64'h120);
    chk("beq.branch_count", branch_count, 1);
    chk("beq.mispredict_count", mispredict_count, 1);
    tick();
    chk("beq.drain_valid", out_valid, 0);

    // Directed vectors, back to back
    for (int v = 0; v < 10; v++) begin
      drive(vecs[v].isb, vecs[v].f3, vecs[v].a, vecs[v].b, vecs[v].p, vecs[v].i, vecs[v].pt);
      tick();
      chk($sformatf("vec%0d.out_valid", v), out_valid, 1);
      chk($sformatf("vec%0d.taken", v), taken, vecs[v].e_tk);
      chk($sformatf("vec%0d.illegal", v), illegal, vecs[v].e_il);
      chk($sformatf("vec%0d.redirect", v), redirect, vecs[v].e_rd);
      chk($sformatf("vec%0d.target", v), target, vecs[v].e_tg);
      chk($sformatf("vec%0d.redirect_pc", v), redirect_pc, vecs[v].e_rp);
    end
    in_valid = 1'b0;
    chk("vec.branch_count", branch_count, 9);
    chk("vec.mispredict_count", mispredict_count, 4);
    tick();

    // Backpressure: result A held for three cycles while B waits
    out_ready = 1'b0;
    drive(1, 3'b000, 64'd2, 64'd2, 64'h1000, 64'h10, 1);
    tick();
    chk("bp.a_valid", out_valid, 1);
    chk("bp.in_ready_low", in_ready, 0);
    drive(1, 3'b001, 64'd1, 64'd2, 64'h2000, 64'h30, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("bp.hold%0d.valid", c), out_valid, 1);
      chk($sformatf("bp.hold%0d.target", c), target, 64'h1010);
      chk($sformatf("bp.hold%0d.taken", c), taken, 1);
      chk($sformatf("bp.hold%0d.redirect", c), redirect, 0);
      chk($sformatf("bp.hold%0d.in_ready", c), in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.in_ready_high", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp.b_valid", out_valid, 1);
    chk("bp.b_target", target, 64'h2030);
    chk("bp.b_redirect", redirect, 1);
    chk("bp.b_redirect_pc", redirect_pc, 64'h2030);
    chk("bp.branch_count", branch_count, 11);
    chk("bp.mispredict_count", mispredict_count, 5);

    // Asynchronous reset while a result is held
    out_ready = 1'b0;
    drive(1, 3'b000, 64'd1, 64'd1, 64'h40, 64'h8, 1);
    tick();
    in_valid = 1'b0;
    chk("rst.pre_valid", out_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("rst.out_valid", out_valid, 0);
    chk("rst.branch_count", branch_count, 0);
    chk("rst.mispredict_count", mispredict_count, 0);
    chk("rst.target", target, 0);
    chk("rst.taken", taken, 0);
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    for (int e = 0; e < BHT_ENTRIES; e++) begin
      fetch_pc = 64'(e * 4);
      #1;
      chk($sformatf("rst.bht%0d", e), fetch_pred_taken, 0);
    end

    // BHT training at pc 0x40, including saturation at both ends
    fetch_pc = 64'h40;
    pre_ctr = 1;
    for (int t = 0; t < 10; t++) begin
      drive(1, train_dir[t] ? 3'b000 : 3'b001, 64'd6, 64'd6, 64'h40, 64'h4, 0);
      #1;
      chk($sformatf("bht.pre%0d", t), fetch_pred_taken, pre_ctr >= 2);
      tick();
      chk($sformatf("bht.post%0d", t), fetch_pred_taken, train_ctr[t] >= 2);
      pre_ctr = train_ctr[t];
    end
    chk("bht.branch_count", branch_count, 10);
    chk("bht.mispredict_count", mispredict_count, 6);

    // Illegal funct3 and non-branch leave BHT and counters alone
    drive(1, 3'b010, 64'd6, 64'd6, 64'h40, 64'h4, 1);
    tick();
    chk("ill.illegal", illegal, 1);
    chk("ill.taken", taken, 0);
    chk("ill.redirect", redirect, 0);
    chk("ill.bht", fetch_pred_taken, 1);
    drive(0, 3'b001, 64'd6, 64'd6, 64'h40, 64'h4, 1);
    tick();
    in_valid = 1'b0;
    chk("nb.illegal", illegal, 0);
    chk("nb.taken", taken, 0);
    chk("nb.redirect", redirect, 0);
    chk("nb.target", target, 64'h44);
    chk("nb.bht", fetch_pred_taken, 1);
    chk("nb.branch_count", branch_count, 10);
    chk("nb.mispredict_count", mispredict_count, 6);

    // Randomized run against the model, from a fresh reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int e = 0; e < BHT_ENTRIES; e++) m_bht[e] = 2'd1;
    m_valid = 0; m_tk = 0; m_il = 0; m_rd = 0; m_tg = 0; m_rp = 0; m_br = 0; m_mp = 0;

    for (int n = 0; n < 1500; n++) begin
      in_valid   = ($urandom_range(3) != 0);
      out_ready  = ($urandom_range(3) != 0);
      is_branch  = ($urandom_range(7) != 0);
      funct3     = 3'($urandom_range(7));
      rs1        = pick_operand();
      rs2        = ($urandom_range(2) == 0) ? rs1 : pick_operand();
      pc         = {$urandom, $urandom};
      imm        = ($urandom_range(1) == 0) ? 64'($urandom_range(255)) << 1 : {$urandom, $urandom};
      pred_taken = 1'($urandom_range(1));
      fetch_pc   = ($urandom_range(1) == 0) ? pc : {$urandom, $urandom};
      #1;
      exp_ready = !m_valid || out_ready;
      chk("rnd.in_ready", in_ready, exp_ready);
      chk("rnd.fetch_pred", fetch_pred_taken, m_bht[fetch_pc[5:2]][1]);
      if (in_valid && exp_ready) begin
        ref_resolve(is_branch, funct3, rs1, rs2, pc, imm, pred_taken, r_tk, r_il, r_rd, r_tg, r_rp);
        m_valid = 1; m_tk = r_tk; m_il = r_il; m_rd = r_rd; m_tg = r_tg; m_rp = r_rp;
        if (is_branch && !r_il) begin
          if (r_tk && m_bht[pc[5:2]] != 2'd3) m_bht[pc[5:2]] = m_bht[pc[5:2]] + 2'd1;
          if (!r_tk && m_bht[pc[5:2]] != 2'd0) m_bht[pc[5:2]] = m_bht[pc[5:2]] - 2'd1;
          m_br = m_br + 1;
          if (r_rd) m_mp = m_mp + 1;
        end
      end else if (out_ready) begin
        m_valid = 0;
      end
      tick();
      chk("rnd.out_valid", out_valid, m_valid);
      chk("rnd.taken", taken, m_tk);
      chk("rnd.illegal", illegal, m_il);
      chk("rnd.redirect", redirect, m_rd);
      chk("rnd.target", target, m_tg);
      chk("rnd.redirect_pc", redirect_pc, m_rp);
      chk("rnd.branch_count", branch_count, m_br);
      chk("rnd.mispredict_count", mispredict_count, m_mp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
